mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
Main control state machine for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives every datapath select and enable, including ALUSrcA to the ALU source-A mux (1 = register A, 0 = PC). A mem_ready handshake lets it stall on slow memory.

Parameters:
- OPW, 6, opcode width.
- SW_ILLEGAL_TRAP, 0, illegal-opcode handling. 0 = return to FETCH. 1 = park in HALT until reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Op  in  6  opcode field from the instruction register.
- Zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- IorD  out  1  memory address select. 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- RegDst  out  1  destination register select. 1 = rd, 0 = rt.
- MemtoReg  out  1  writeback select. 1 = data register, 0 = ALUOut.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU source A. 1 = register A, 0 = PC.
- ALUSrcB  out  2  ALU source B. 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2.
- ALUOp  out  2  ALU operation. 00 = add, 01 = sub, 10 = use funct.
- PCSrc  out  2  next-PC select. 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- PCEn  out  1  PC write enable. PCEn = PCWrite | (Branch & Zero).
- illegal_op  out  1  one-cycle pulse on an undecodable opcode.
- halted  out  1  high while in HALT.

Behaviour:
- Reset (async): state := RST. All outputs are 0 in RST. The next edge moves RST -> FETCH unconditionally.
- Outputs are decoded combinationally from the state register. mem_ready, Zero and Op qualify some outputs as noted. Any output not listed for a state is 0.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite = PCWrite = mem_ready.
  - Stays in FETCH while mem_ready=0, so the PC is incremented exactly once per instruction.
  - mem_ready=1 -> DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by Op:
  - 100011 (lw) or 101011 (sw) -> MEMADR.
  - 000000 (R-type) -> EXEC.
  - 000100 (beq) -> BRANCH.
  - 001000 (addi) -> ADDIEX.
  - 000010 (j) -> JUMP.
  - Any other Op: illegal_op=1 this cycle; next state is FETCH (SW_ILLEGAL_TRAP=0) or HALT (=1).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: IorD=1. Holds until mem_ready=1, then -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1. MemWrite stays high while waiting. On mem_ready=1 -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. PCEn=Zero -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- HALT: halted=1, all enables 0. Self-loop until reset.
- Latency with mem_ready always 1 (cycles including FETCH):
  - lw = 5, sw = 4, R-type = 4, addi = 4, beq = 3, j = 3.
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Reset asserted mid-instruction: immediately RST, all write enables drop in the same delta. No partial register or memory write occurs after reset assertion.
- Invariant: at most one of RegWrite, MemWrite and PCEn-from-PCWrite is asserted in any state other than FETCH.
- Unreachable state encodings decode to all-zero outputs and next state FETCH.

Decomposition:
- Package mc_ctrl_pkg holds:
  - state enum (RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, HALT);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - ALUSrcB, ALUOp and PCSrc encodings.
- One sub-module, mc_ctrl_outdec: purely combinational, maps (state, mem_ready, Zero) to the output bundle. The FSM top holds only the state register and next-state logic.

Test Plan:
- Reset held 3 cycles, then released with mem_ready=1, Op=000000 -> cycle 0 all outputs 0; FETCH asserts IRWrite=PCEn=1, ALUSrcA=0, ALUSrcB=01; DECODE; EXEC with ALUSrcA=1, ALUOp=10; ALUWB with RegWrite=1, RegDst=1; back to FETCH after 4 cycles.
- lw (100011) with mem_ready low for 2 cycles in MEMRD -> IorD=1 held 3 cycles; MEMWB asserts MemtoReg=RegWrite=1 once; total 7 cycles.
- beq (000100): Zero=1 gives PCEn=1, PCSrc=01, ALUOp=01; repeat with Zero=0 gives PCEn=0; both return to FETCH after 3 cycles.
- FETCH with mem_ready=0 for 4 cycles -> IRWrite=PCEn=0 throughout; exactly one PCEn pulse when mem_ready rises.
- Op=111111 with SW_ILLEGAL_TRAP=0 gives a one-cycle illegal_op pulse in DECODE, then FETCH. With =1 it reaches HALT, halted=1, no enables, until reset.
- sw (101011) with reset asserted during MEMWR -> MemWrite falls asynchronously in the same cycle; after release the sequence restarts at RST then FETCH.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control path.
// Contents: the control state encoding, the opcodes the controller decodes,
// the ALU source-B / ALU operation / next-PC select encodings, and the
// packed bundle of datapath controls that the output decoder produces.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    RST    = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    JUMP   = 4'd12,
    HALT   = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational output decoder for the multicycle control FSM.
// Ports:
//   state     - current control state
//   mem_ready - memory access completes this cycle (qualifies FETCH loads)
//   zero      - ALU zero flag (qualifies the branch PC write)
//   ctrl      - full bundle of datapath selects and enables
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  input  logic       zero,
  output ctrl_t      ctrl
);

  logic pc_write;
  logic branch;

  // Every control defaults low so RST, HALT and any unreachable encoding
  // drive no enables. FETCH only commits IR and PC on the cycle memory
  // delivers, so a stalled fetch increments the PC exactly once.
  always_comb begin
    ctrl     = '0;
    pc_write = 1'b0;
    branch   = 1'b0;
    case (state)
      FETCH: begin
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        pc_write       = mem_ready;
      end
      DECODE: ctrl.alu_src_b = SRCB_IMMSH;
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      MEMRD: ctrl.iord = 1'b1;
      MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        branch         = 1'b1;
      end
      ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      ADDIWB: ctrl.reg_write = 1'b1;
      JUMP: begin
        ctrl.pc_src = PCSRC_JUMP;
        pc_write    = 1'b1;
      end
      HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
    ctrl.pc_en = pc_write | (branch & zero);
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Main control state machine for the multicycle MIPS datapath.
// Sequences each instruction through fetch/decode/execute/memory/writeback,
// stalling in FETCH, MEMRD and MEMWR until mem_ready.
// Ports:
//   clk, reset      - rising-edge clock, asynchronous active-high reset
//   Op, Zero        - opcode from IR, ALU zero flag
//   mem_ready       - memory access completes this cycle
//   IorD ... PCEn   - datapath selects and enables
//   illegal_op      - one-cycle pulse in DECODE on an undecodable opcode
//   halted          - high while parked in HALT
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OPW             = 6,
  parameter bit SW_ILLEGAL_TRAP = 1'b0
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] Op,
  input  logic           Zero,
  input  logic           mem_ready,
  output logic           IorD,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSrc,
  output logic           PCEn,
  output logic           illegal_op,
  output logic           halted
);

  state_t state_q;
  state_t state_d;
  ctrl_t  ctrl;

  // Next-state decode. Unreachable encodings recover to FETCH; HALT is
  // left only by reset.
  always_comb begin
    state_d    = FETCH;
    illegal_op = 1'b0;
    case (state_q)
      RST:    state_d = FETCH;
      FETCH:  state_d = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = SW_ILLEGAL_TRAP ? HALT : FETCH;
          end
        endcase
      end
      MEMADR: state_d = (Op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
      EXEC:   state_d = ALUWB;
      BRANCH: state_d = FETCH;
      ADDIEX: state_d = ADDIWB;
      HALT:   state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Outputs decode from state_q, so an asynchronous reset drops every
  // write enable immediately, without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RST;
    else       state_q <= state_d;
  end

  mc_ctrl_outdec u_outdec (
    .state     (state_q),
    .mem_ready (mem_ready),
    .zero      (Zero),
    .ctrl      (ctrl)
  );

  assign IorD     = ctrl.iord;
  assign MemWrite = ctrl.mem_write;
  assign IRWrite  = ctrl.ir_write;
  assign RegDst   = ctrl.reg_dst;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegWrite = ctrl.reg_write;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ALUOp    = ctrl.alu_op;
  assign PCSrc    = ctrl.pc_src;
  assign PCEn     = ctrl.pc_en;
  assign halted   = ctrl.halted;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm. Two instances share all inputs:
// dut0 returns to FETCH on an illegal opcode, dut1 traps in HALT.
// Each driven cycle pushes both expected output vectors; the monitor pops
// and compares on the falling edge.
// Vector bit order: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA
// ALUSrcB[1:0] ALUOp[1:0] PCSrc[1:0] PCEn illegal_op halted.
module tb_mc_control_fsm;

  localparam logic [15:0] E_ZERO    = 16'b0_0_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [15:0] E_FETCHR  = 16'b0_0_1_0_0_0_0_01_00_00_1_0_0;
  localparam logic [15:0] E_FETCHW  = 16'b0_0_0_0_0_0_0_01_00_00_0_0_0;
  localparam logic [15:0] E_DECODE  = 16'b0_0_0_0_0_0_0_11_00_00_0_0_0;
  localparam logic [15:0] E_DECILL  = 16'b0_0_0_0_0_0_0_11_00_00_0_1_0;
  localparam logic [15:0] E_MEMADR  = 16'b0_0_0_0_0_0_1_10_00_00_0_0_0;
  localparam logic [15:0] E_MEMRD   = 16'b1_0_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [15:0] E_MEMWB   = 16'b0_0_0_0_1_1_0_00_00_00_0_0_0;
  localparam logic [15:0] E_MEMWR   = 16'b1_1_0_0_0_0_0_00_00_00_0_0_0;
  localparam logic [15:0] E_EXEC    = 16'b0_0_0_0_0_0_1_00_10_00_0_0_0;
  localparam logic [15:0] E_ALUWB   = 16'b0_0_0_1_0_1_0_00_00_00_0_0_0;
  localparam logic [15:0] E_BRZ1    = 16'b0_0_0_0_0_0_1_00_01_01_1_0_0;
  localparam logic [15:0] E_BRZ0    = 16'b0_0_0_0_0_0_1_00_01_01_0_0_0;
  localparam logic [15:0] E_ADDIEX  = 16'b0_0_0_0_0_0_1_10_00_00_0_0_0;
  localparam logic [15:0] E_ADDIWB  = 16'b0_0_0_0_0_1_0_00_00_00_0_0_0;
  localparam logic [15:0] E_JUMP    = 16'b0_0_0_0_0_0_0_00_00_10_1_0_0;
  localparam logic [15:0] E_HALT    = 16'b0_0_0_0_0_0_0_00_00_00_0_0_1;

  typedef struct {
    logic [15:0] exp0;
    logic [15:0] exp1;
    string       name;
  } sbEntry_t;

  logic       clock;
  logic       reset;
  logic [5:0] op;
  logic       zero;
  logic       memReady;

  logic       iorD0, memWrite0, irWrite0, regDst0, memtoReg0, regWrite0, aluSrcA0;
  logic [1:0] aluSrcB0, aluOp0, pcSrc0;
  logic       pcEn0, illegalOp0, halted0;
  logic       iorD1, memWrite1, irWrite1, regDst1, memtoReg1, regWrite1, aluSrcA1;
  logic [1:0] aluSrcB1, aluOp1, pcSrc1;
  logic       pcEn1, illegalOp1, halted1;

  sbEntry_t scoreboard[$];
  int vectorCount;
  int missCount;

  mc_control_fsm #(.OPW(6), .SW_ILLEGAL_TRAP(1'b0)) dut0 (
    .clk(clock), .reset(reset), .Op(op), .Zero(zero), .mem_ready(memReady),
    .IorD(iorD0), .MemWrite(memWrite0), .IRWrite(irWrite0), .RegDst(regDst0),
    .MemtoReg(memtoReg0), .RegWrite(regWrite0), .ALUSrcA(aluSrcA0),
    .ALUSrcB(aluSrcB0), .ALUOp(aluOp0), .PCSrc(pcSrc0), .PCEn(pcEn0),
    .illegal_op(illegalOp0), .halted(halted0)
  );

  mc_control_fsm #(.OPW(6), .SW_ILLEGAL_TRAP(1'b1)) dut1 (
    .clk(clock), .reset(reset), .Op(op), .Zero(zero), .mem_ready(memReady),
    .IorD(iorD1), .MemWrite(memWrite1), .IRWrite(irWrite1), .RegDst(regDst1),
    .MemtoReg(memtoReg1), .RegWrite(regWrite1), .ALUSrcA(aluSrcA1),
    .ALUSrcB(aluSrcB1), .ALUOp(aluOp1), .PCSrc(pcSrc1), .PCEn(pcEn1),
    .illegal_op(illegalOp1), .halted(halted1)
  );

  // Free-running clock, 10 time units per cycle.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compares one DUT's packed outputs against the expected vector.
  task automatic checkOutput(input string name, input int idx,
                             input logic [15:0] got, input logic [15:0] exp);
    vectorCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s dut%0d got %b expected %b", name, idx, got, exp);
    end
  endtask

  // Monitor: every falling edge with a pending expectation is checked.
  always @(negedge clock) begin
    if (scoreboard.size() > 0) begin
      sbEntry_t e;
      e = scoreboard.pop_front();
      checkOutput(e.name, 0,
        {iorD0, memWrite0, irWrite0, regDst0, memtoReg0, regWrite0, aluSrcA0,
         aluSrcB0, aluOp0, pcSrc0, pcEn0, illegalOp0, halted0}, e.exp0);
      checkOutput(e.name, 1,
        {iorD1, memWrite1, irWrite1, regDst1, memtoReg1, regWrite1, aluSrcA1,
         aluSrcB1, aluOp1, pcSrc1, pcEn1, illegalOp1, halted1}, e.exp1);
    end
  end

  // Drives one cycle's inputs just after the rising edge and records what
  // both DUTs must present for the rest of that cycle.
  task automatic applyStimulus(input logic rst, input logic mr, input logic [5:0] opc,
                               input logic z, input logic [15:0] e0,
                               input logic [15:0] e1, input string name);
    sbEntry_t e;
    @(posedge clock);
    #1;
    reset    = rst;
    memReady = mr;
    op       = opc;
    zero     = z;
    e.exp0 = e0;
    e.exp1 = e1;
    e.name = name;
    scoreboard.push_back(e);
  endtask

  initial begin
    vectorCount = 0;
    missCount   = 0;
    reset    = 1'b1;
    memReady = 1'b1;
    op       = 6'b000000;
    zero     = 1'b0;

    // Reset held three cycles, then R-type with no stalls
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 6'b000000, 0, E_ZERO, E_ZERO, "reset_hold");
    applyStimulus(0, 1, 6'b000000, 0, E_ZERO,   E_ZERO,   "rst_state");
    applyStimulus(0, 1, 6'b000000, 0, E_FETCHR, E_FETCHR, "r_fetch");
    applyStimulus(0, 1, 6'b000000, 0, E_DECODE, E_DECODE, "r_decode");
    applyStimulus(0, 1, 6'b000000, 0, E_EXEC,   E_EXEC,   "r_exec");
    applyStimulus(0, 1, 6'b000000, 0, E_ALUWB,  E_ALUWB,  "r_aluwb");

    // lw with two stall cycles in MEMRD: seven cycles total
    applyStimulus(0, 1, 6'b100011, 0, E_FETCHR, E_FETCHR, "lw_fetch");
    applyStimulus(0, 1, 6'b100011, 0, E_DECODE, E_DECODE, "lw_decode");
    applyStimulus(0, 1, 6'b100011, 0, E_MEMADR, E_MEMADR, "lw_memadr");
    applyStimulus(0, 0, 6'b100011, 0, E_MEMRD,  E_MEMRD,  "lw_memrd_wait1");
    applyStimulus(0, 0, 6'b100011, 0, E_MEMRD,  E_MEMRD,  "lw_memrd_wait2");
    applyStimulus(0, 1, 6'b100011, 0, E_MEMRD,  E_MEMRD,  "lw_memrd_done");
    applyStimulus(0, 1, 6'b100011, 0, E_MEMWB,  E_MEMWB,  "lw_memwb");

    // beq taken then not taken
    applyStimulus(0, 1, 6'b000100, 1, E_FETCHR, E_FETCHR, "beq1_fetch");
    applyStimulus(0, 1, 6'b000100, 1, E_DECODE, E_DECODE, "beq1_decode");
    applyStimulus(0, 1, 6'b000100, 1, E_BRZ1,   E_BRZ1,   "beq_taken");
    applyStimulus(0, 1, 6'b000100, 0, E_FETCHR, E_FETCHR, "beq0_fetch");
    applyStimulus(0, 1, 6'b000100, 0, E_DECODE, E_DECODE, "beq0_decode");
    applyStimulus(0, 1, 6'b000100, 0, E_BRZ0,   E_BRZ0,   "beq_not_taken");

    // Fetch stalled four cycles, then addi
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 6'b001000, 0, E_FETCHW, E_FETCHW, "fetch_stall");
    applyStimulus(0, 1, 6'b001000, 0, E_FETCHR, E_FETCHR, "addi_fetch");
    applyStimulus(0, 1, 6'b001000, 0, E_DECODE, E_DECODE, "addi_decode");
    applyStimulus(0, 1, 6'b001000, 0, E_ADDIEX, E_ADDIEX, "addi_ex");
    applyStimulus(0, 1, 6'b001000, 0, E_ADDIWB, E_ADDIWB, "addi_wb");

    // j
    applyStimulus(0, 1, 6'b000010, 0, E_FETCHR, E_FETCHR, "j_fetch");
    applyStimulus(0, 1, 6'b000010, 0, E_DECODE, E_DECODE, "j_decode");
    applyStimulus(0, 1, 6'b000010, 0, E_JUMP,   E_JUMP,   "j_jump");

    // sw without stalls
    applyStimulus(0, 1, 6'b101011, 0, E_FETCHR, E_FETCHR, "sw_fetch");
    applyStimulus(0, 1, 6'b101011, 0, E_DECODE, E_DECODE, "sw_decode");
    applyStimulus(0, 1, 6'b101011, 0, E_MEMADR, E_MEMADR, "sw_memadr");
    applyStimulus(0, 1, 6'b101011, 0, E_MEMWR,  E_MEMWR,  "sw_memwr");

    // Illegal opcode: dut0 refetches, dut1 parks in HALT
    applyStimulus(0, 1, 6'b111111, 0, E_FETCHR, E_FETCHR, "ill_fetch");
    applyStimulus(0, 1, 6'b111111, 0, E_DECILL, E_DECILL, "ill_decode");
    applyStimulus(0, 1, 6'b000000, 0, E_FETCHR, E_HALT,   "ill_after");
    applyStimulus(0, 1, 6'b000000, 0, E_DECODE, E_HALT,   "halt_hold1");
    applyStimulus(0, 1, 6'b000000, 0, E_EXEC,   E_HALT,   "halt_hold2");
    applyStimulus(0, 1, 6'b000000, 0, E_ALUWB,  E_HALT,   "halt_hold3");

    // sw stalled in MEMWR, then reset asserted mid-cycle
    applyStimulus(0, 1, 6'b101011, 0, E_FETCHR, E_HALT,   "swr_fetch");
    applyStimulus(0, 1, 6'b101011, 0, E_DECODE, E_HALT,   "swr_decode");
    applyStimulus(0, 1, 6'b101011, 0, E_MEMADR, E_HALT,   "swr_memadr");
    applyStimulus(0, 0, 6'b101011, 0, E_MEMWR,  E_HALT,   "swr_memwr_wait");
    applyStimulus(1, 0, 6'b101011, 0, E_ZERO,   E_ZERO,   "swr_async_reset");
    applyStimulus(1, 1, 6'b000000, 0, E_ZERO,   E_ZERO,   "swr_reset_hold");
    applyStimulus(0, 1, 6'b000000, 0, E_ZERO,   E_ZERO,   "swr_rst_state");
    applyStimulus(0, 1, 6'b000000, 0, E_FETCHR, E_FETCHR, "restart_fetch");
    applyStimulus(0, 1, 6'b000000, 0, E_DECODE, E_DECODE, "restart_decode");
    applyStimulus(0, 1, 6'b000000, 0, E_EXEC,   E_EXEC,   "restart_exec");
    applyStimulus(0, 1, 6'b000000, 0, E_ALUWB,  E_ALUWB,  "restart_aluwb");

    // Let the monitor drain the last expectation
    repeat (2) @(posedge clock);
    if (scoreboard.size() != 0) begin
      missCount++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", scoreboard.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
